// File: rtl/alu_8bit_if.sv
// Operand/result bundle for alu_8bit: operation select and operands in,
// registered result and flags out.
interface alu_8bit_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       ALUctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;
  logic             Overflow;

  // Requester side: drives the operation, observes the registered result
  modport master (
    output ALUctl, A, B,
    input  ALUOut, Zero, Overflow
  );

  // ALU side: consumes the operation, produces the registered result
  modport slave (
    input  ALUctl, A, B,
    output ALUOut, Zero, Overflow
  );
endinterface

// File: rtl/alu_8bit.sv
// Single-cycle-latency ALU: AND/OR/ADD/SUB/SLT/NOR decoded from ALUctl,
// result, zero flag and signed-overflow flag registered together.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_8bit_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Signed overflow of a + b: operands agree in sign, sum disagrees
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
  endfunction

  // Signed overflow of a - b: operands differ in sign, difference flips from a
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]);
  endfunction

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum_p0;
  logic signed [WIDTH-1:0] diff_p0;
  logic                    sub_ovf_p0;
  logic                    less_p0;
  logic        [WIDTH-1:0] result_p0;
  logic                    ovf_p0;

  logic        [WIDTH-1:0] result_p1;
  logic                    zero_p1;
  logic                    ovf_p1;

  assign a_s = bus.A;
  assign b_s = bus.B;

  // ---- stage p0: combinational decode of the current inputs ----
  // Subtraction is built as a + ~b + 1 so SUB and SLT share one adder path;
  // SLT corrects the sign bit with the overflow so wrapped differences still compare right.
  always_comb begin
    sum_p0     = a_s + b_s;
    diff_p0    = a_s + ~b_s + WIDTH'(1);
    sub_ovf_p0 = sub_ovf(a_s, b_s, diff_p0);
    less_p0    = diff_p0[MSB] ^ sub_ovf_p0;
    result_p0  = '0;
    ovf_p0     = 1'b0;
    case (bus.ALUctl)
      OP_AND: result_p0 = bus.A & bus.B;
      OP_OR:  result_p0 = bus.A | bus.B;
      OP_ADD: begin
        result_p0 = sum_p0;
        ovf_p0    = add_ovf(a_s, b_s, sum_p0);
      end
      OP_SUB: begin
        result_p0 = diff_p0;
        ovf_p0    = sub_ovf_p0;
      end
      OP_SLT: result_p0 = {{(WIDTH-1){1'b0}}, less_p0};
      OP_NOR: result_p0 = ~(bus.A | bus.B);
      default: begin
        result_p0 = '0;
        ovf_p0    = 1'b0;
      end
    endcase
  end

  // ---- stage p1: output register; zero derived from the same captured result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b1;
      ovf_p1    <= 1'b0;
    end else begin
      result_p1 <= result_p0;
      zero_p1   <= (result_p0 == '0);
      ovf_p1    <= ovf_p0;
    end
  end

  assign bus.ALUOut   = result_p1;
  assign bus.Zero     = zero_p1;
  assign bus.Overflow = ovf_p1;

endmodule

// File: tb/tb_alu_8bit.sv
// Testbench for alu_8bit: directed corner cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_alu_8bit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  alu_8bit_if #(.WIDTH(8)) bus ();

  alu_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: operations evaluated as mathematical integers, overflow is
  // "true result outside the signed 8-bit range".
  task automatic model(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic z, output logic ovf);
    int sa, sb, full;
    sa  = $signed(a);
    sb  = $signed(b);
    res = 8'h00;
    ovf = 1'b0;
    case (ctl)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  begin full = sa + sb; res = full[7:0]; ovf = (full > 127) || (full < -128); end
      4'd6:  begin full = sa - sb; res = full[7:0]; ovf = (full > 127) || (full < -128); end
      4'd7:  res = (sa < sb) ? 8'd1 : 8'd0;
      4'd12: res = ~(a | b);
      default: res = 8'h00;
    endcase
    z = (res == 8'h00);
  endtask

  // Drive an operation at the falling edge, sample 1 time unit after the next rising edge
  task automatic apply(input string tag, input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] er;
    logic       ez, eo;
    @(negedge clk);
    bus.ALUctl = ctl;
    bus.A      = a;
    bus.B      = b;
    model(ctl, a, b, er, ez, eo);
    @(posedge clk);
    #1;
    check({tag, ".out"}, 32'(bus.ALUOut), 32'(er));
    check({tag, ".zero"}, 32'(bus.Zero), 32'(ez));
    check({tag, ".ovf"}, 32'(bus.Overflow), 32'(eo));
  endtask

  logic [3:0] legal_ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
  logic [7:0] edge_vals [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

  initial begin
    logic [3:0] ctl;
    logic [7:0] a, b;
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    bus.ALUctl = 4'd2;
    bus.A      = 8'h11;
    bus.B      = 8'h22;

    // Reset state, held across clock edges
    #3;
    check("rst.out", 32'(bus.ALUOut), 32'h00);
    check("rst.zero", 32'(bus.Zero), 32'h1);
    check("rst.ovf", 32'(bus.Overflow), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.out", 32'(bus.ALUOut), 32'h00);
    @(negedge clk);
    rst = 1'b0;

    // Logic ops
    apply("and10", 4'd0, 8'h01, 8'h00);
    apply("or10", 4'd1, 8'h01, 8'h00);
    apply("nor10", 4'd12, 8'h01, 8'h00);
    apply("and11", 4'd0, 8'h01, 8'h01);
    apply("or11", 4'd1, 8'h01, 8'h01);
    apply("nor11", 4'd12, 8'h01, 8'h01);
    check("nor11.lit", 32'(bus.ALUOut), 32'hFE);

    // ADD
    apply("add11", 4'd2, 8'h01, 8'h01);
    check("add11.lit", 32'(bus.ALUOut), 32'h02);
    apply("add7f", 4'd2, 8'h7F, 8'h01);
    check("add7f.lit_ovf", 32'(bus.Overflow), 32'h1);
    apply("addff", 4'd2, 8'hFF, 8'h01);
    check("addff.lit_zero", 32'(bus.Zero), 32'h1);

    // SUB
    apply("sub01", 4'd6, 8'h00, 8'h01);
    check("sub01.lit", 32'(bus.ALUOut), 32'hFF);
    apply("sub11", 4'd6, 8'h01, 8'h01);
    apply("sub80", 4'd6, 8'h80, 8'h01);
    check("sub80.lit_ovf", 32'(bus.Overflow), 32'h1);

    // SLT including overflowing differences
    apply("slt01", 4'd7, 8'h00, 8'h01);
    apply("slt10", 4'd7, 8'h01, 8'h00);
    apply("slt11", 4'd7, 8'h01, 8'h01);
    apply("slt807f", 4'd7, 8'h80, 8'h7F);
    check("slt807f.lit", 32'(bus.ALUOut), 32'h01);
    apply("slt7f80", 4'd7, 8'h7F, 8'h80);

    // Latency, input changes between edges, mid-stream reset
    apply("lat", 4'd2, 8'h03, 8'h04);
    check("lat.lit", 32'(bus.ALUOut), 32'h07);
    bus.A = 8'h55;
    bus.ALUctl = 4'd1;
    #2;
    check("hold.out", 32'(bus.ALUOut), 32'h07);
    rst = 1'b1;
    #1;
    check("midrst.out", 32'(bus.ALUOut), 32'h00);
    check("midrst.zero", 32'(bus.Zero), 32'h1);
    check("midrst.ovf", 32'(bus.Overflow), 32'h0);
    @(posedge clk);
    #1;
    check("midrst_edge.out", 32'(bus.ALUOut), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    apply("post_rst", 4'd2, 8'h7F, 8'h7F);
    apply("unused5", 4'd5, 8'hFF, 8'h0F);
    apply("unused15", 4'd15, 8'h80, 8'h80);

    // Randomized operations
    for (int i = 0; i < 300; i++) begin
      ctl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 5)];
      a   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 8'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 8'($urandom);
      apply("rand", ctl, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
